down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
Loadable down-counting timer with one-shot and auto-reload modes.
- Software or an FSM loads a terminal count, starts the timer, and receives a one-cycle `expire` pulse when the count runs out.
- It is the decrementing complement of the free-running up-counter. It sits next to it in the timing/control subsystem for timeouts and periodic events.

Parameters:
WIDTH, 8, width of count and load value
PRESC_WIDTH, 4, width of prescaler divide value (used only with DOWN_TIMER_PRESCALE_EN)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  load pulse: count and reload register take load_value
load_value  input  WIDTH  value captured on load
start  input  1  start/resume request
stop  input  1  pause request
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at each expiry
enable  input  1  tick qualifier; count decrements only on cycles with a tick
count  output  WIDTH  current count value (registered)
busy  output  1  high while state is RUN
paused  output  1  high while state is PAUSE
expire  output  1  one-cycle registered pulse on terminal count

Behaviour:
- Reset is asynchronous on rst_n low, synchronous release. On reset:
  - count = 0, reload register = 0, state = IDLE
  - busy = 0, paused = 0, expire = 0
- States are IDLE, RUN and PAUSE. busy and paused are decoded from the state register (no extra latency).
- `tick` = enable (without the optional feature).
- Command priority in a cycle: load > stop > start.
- load (any state):
  - count <= load_value, reload <= load_value, state <= IDLE, expire <= 0.
  - start and stop are ignored in the same cycle.
- IDLE:
  - start with count != 0 -> RUN next cycle.
  - start with count == 0 -> ignored; no expire.
  - stop -> ignored.
- RUN:
  - stop -> PAUSE; count is held.
  - Tick with count > 1 -> count <= count - 1.
  - Tick with count == 1 and auto_reload = 0 -> count <= 0, state <= IDLE, expire <= 1.
  - Tick with count == 1 and auto_reload = 1 -> count <= reload, stay RUN, expire <= 1. Period is `reload` ticks.
  - No tick -> count held.
  - stop and a tick in the same cycle: stop wins, no decrement.
- PAUSE:
  - start -> RUN; decrements resume on the next tick.
  - Ticks are ignored.
  - stop -> no effect.
- expire is high for exactly one cycle per expiry and is 0 in all other cycles.
- count never wraps below 0 and never leaves the range 0..reload after a load.
- Latency: start registered at edge E0 -> busy from E0. With enable held at 1, the first decrement is at edge E1.
- Reset asserted mid-run: immediate return to reset values; no expire is generated.

Optional Feature:
DOWN_TIMER_PRESCALE_EN
- Defined:
  - Adds input `presc` [PRESC_WIDTH] and an internal prescale counter.
  - tick = enable && (presc_cnt == presc). On a tick, presc_cnt <= 0; otherwise presc_cnt increments on each enabled cycle.
  - presc_cnt clears on reset, load, and the IDLE/PAUSE -> RUN transition.
  - Decrement rate is one per (presc + 1) enabled cycles; presc = 0 equals no prescaling.
- Not defined:
  - No presc port and no prescale counter.
  - tick = enable.

Test Plan:
- Reset with load=1, start=1 held -> count=0, busy=0, paused=0, expire=0 while rst_n=0.
- One-shot: load 5, start, enable=1 -> count 5,4,3,2,1,0 on consecutive edges; expire high one cycle with count=0; busy drops in the same cycle.
- Auto-reload: load 3, auto_reload=1, start -> count 3,2,1,3,2,1,...; expire every 3rd cycle; busy stays 1.
- Pause/resume: load 10, start, stop after count=7 -> count holds 7 for 4 cycles with paused=1; start -> 6,5,...; stop+start in the same cycle -> PAUSE.
- Edge cases:
  - Start with count=0 -> stays IDLE, no expire.
  - Load 4 during RUN at count=2 -> count=4, IDLE, no expire.
  - enable=0 during RUN -> count frozen.
- With DOWN_TIMER_PRESCALE_EN, presc=2, load 2, start -> count decrements every 3rd cycle; expire on cycle 6 after start.

Source files
------------

// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer: commands and load value in, count and status out.
// With DOWN_TIMER_PRESCALE_EN defined the bundle also carries the prescaler divide value.
interface down_timer_if #(
    parameter int WIDTH = 8
`ifdef DOWN_TIMER_PRESCALE_EN
    , parameter int PRESC_WIDTH = 4
`endif
);

    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic             enable;
`ifdef DOWN_TIMER_PRESCALE_EN
    logic [PRESC_WIDTH-1:0] presc;
`endif
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             expire;

    modport master (
`ifdef DOWN_TIMER_PRESCALE_EN
        output presc,
`endif
        output load, load_value, start, stop, auto_reload, enable,
        input  count, busy, paused, expire
    );

    modport slave (
`ifdef DOWN_TIMER_PRESCALE_EN
        input  presc,
`endif
        input  load, load_value, start, stop, auto_reload, enable,
        output count, busy, paused, expire
    );

endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes and a one-cycle expire pulse.
// Optional prescaler enabled by defining DOWN_TIMER_PRESCALE_EN.
module down_timer #(
    parameter int WIDTH = 8
`ifdef DOWN_TIMER_PRESCALE_EN
    , parameter int PRESC_WIDTH = 4
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    down_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expire_q, expire_d;
    logic             run_entry;
    logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
    logic [PRESC_WIDTH-1:0] presc_cnt_q;

    assign tick = bus.enable && (presc_cnt_q == bus.presc);

    // Restart the divider on load and on every entry into RUN so the first
    // decrement after a start/resume always takes a full presc+1 enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
        end else if (bus.load || run_entry || tick) begin
            presc_cnt_q <= '0;
        end else if (bus.enable) begin
            presc_cnt_q <= presc_cnt_q + PRESC_WIDTH'(1);
        end
    end
`else
    assign tick = bus.enable;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    // Command priority is load > stop > start; stop also masks a start in IDLE/PAUSE.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expire_d  = 1'b0;
        run_entry = 1'b0;

        if (bus.load) begin
            count_d  = bus.load_value;
            reload_d = bus.load_value;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.stop && bus.start && (count_q != '0)) begin
                        state_d   = RUN;
                        run_entry = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            expire_d = 1'b1;
                            if (bus.auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                PAUSE: begin
                    if (!bus.stop && bus.start) begin
                        state_d   = RUN;
                        run_entry = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.count  = count_q;
    assign bus.busy   = (state_q == RUN);
    assign bus.paused = (state_q == PAUSE);
    assign bus.expire = expire_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed vector bench for down_timer: table-driven main sequence plus hand-written reset
// and prescaler sequences.
module tb_down_timer;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    down_timer_if #(.WIDTH(8)) tif ();

    down_timer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       load;
        logic [7:0] load_value;
        logic       start;
        logic       stop;
        logic       auto_reload;
        logic       enable;
        logic [7:0] exp_count;
        logic       exp_busy;
        logic       exp_paused;
        logic       exp_expire;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic ld, logic [7:0] lv, logic st, logic sp,
                                logic ar, logic en, logic [7:0] c, logic b, logic p, logic e);
        vec_t v;
        v.name = name; v.load = ld; v.load_value = lv; v.start = st; v.stop = sp;
        v.auto_reload = ar; v.enable = en;
        v.exp_count = c; v.exp_busy = b; v.exp_paused = p; v.exp_expire = e;
        return v;
    endfunction

    task automatic applyStimulus(input logic ld, input logic [7:0] lv, input logic st,
                                 input logic sp, input logic ar, input logic en);
        @(negedge clk);
        tif.load        = ld;
        tif.load_value  = lv;
        tif.start       = st;
        tif.stop        = sp;
        tif.auto_reload = ar;
        tif.enable      = en;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] c, input logic b,
                               input logic p, input logic e);
        tests_run++;
        if (tif.count !== c || tif.busy !== b || tif.paused !== p || tif.expire !== e) begin
            tests_failed++;
            $display("[TB] FAIL %s: got count=%0d busy=%b paused=%b expire=%b, expected count=%0d busy=%b paused=%b expire=%b",
                     name, tif.count, tif.busy, tif.paused, tif.expire, c, b, p, e);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset with load/start held must still show reset values.
        rst_n           = 1'b0;
        tif.load        = 1'b1;
        tif.load_value  = 8'hAA;
        tif.start       = 1'b1;
        tif.stop        = 1'b0;
        tif.auto_reload = 1'b0;
        tif.enable      = 1'b1;
`ifdef DOWN_TIMER_PRESCALE_EN
        tif.presc       = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_held", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tif.load  = 1'b0;
        tif.start = 1'b0;
        rst_n     = 1'b1;

        //          name          ld  lv     st sp ar en  count b  p  e
        vecs.push_back(mk("os_load5",   1, 8'd5,  0, 0, 0, 1, 8'd5,  0, 0, 0));
        vecs.push_back(mk("os_start",   0, 8'd0,  1, 0, 0, 1, 8'd5,  1, 0, 0));
        vecs.push_back(mk("os_4",       0, 8'd0,  0, 0, 0, 1, 8'd4,  1, 0, 0));
        vecs.push_back(mk("os_3",       0, 8'd0,  0, 0, 0, 1, 8'd3,  1, 0, 0));
        vecs.push_back(mk("os_2",       0, 8'd0,  0, 0, 0, 1, 8'd2,  1, 0, 0));
        vecs.push_back(mk("os_1",       0, 8'd0,  0, 0, 0, 1, 8'd1,  1, 0, 0));
        vecs.push_back(mk("os_expire",  0, 8'd0,  0, 0, 0, 1, 8'd0,  0, 0, 1));
        vecs.push_back(mk("os_after",   0, 8'd0,  0, 0, 0, 1, 8'd0,  0, 0, 0));
        vecs.push_back(mk("zero_start", 0, 8'd0,  1, 0, 0, 1, 8'd0,  0, 0, 0));
        vecs.push_back(mk("zero_idle",  0, 8'd0,  0, 0, 0, 1, 8'd0,  0, 0, 0));
        vecs.push_back(mk("ar_load3",   1, 8'd3,  0, 0, 1, 1, 8'd3,  0, 0, 0));
        vecs.push_back(mk("ar_start",   0, 8'd0,  1, 0, 1, 1, 8'd3,  1, 0, 0));
        vecs.push_back(mk("ar_2a",      0, 8'd0,  0, 0, 1, 1, 8'd2,  1, 0, 0));
        vecs.push_back(mk("ar_1a",      0, 8'd0,  0, 0, 1, 1, 8'd1,  1, 0, 0));
        vecs.push_back(mk("ar_rel_a",   0, 8'd0,  0, 0, 1, 1, 8'd3,  1, 0, 1));
        vecs.push_back(mk("ar_2b",      0, 8'd0,  0, 0, 1, 1, 8'd2,  1, 0, 0));
        vecs.push_back(mk("ar_1b",      0, 8'd0,  0, 0, 1, 1, 8'd1,  1, 0, 0));
        vecs.push_back(mk("ar_rel_b",   0, 8'd0,  0, 0, 1, 1, 8'd3,  1, 0, 1));
        vecs.push_back(mk("ar_2c",      0, 8'd0,  0, 0, 1, 1, 8'd2,  1, 0, 0));
        vecs.push_back(mk("run_load4",  1, 8'd4,  1, 1, 1, 1, 8'd4,  0, 0, 0));
        vecs.push_back(mk("load_idle",  0, 8'd0,  0, 0, 0, 1, 8'd4,  0, 0, 0));
        vecs.push_back(mk("en0_start",  0, 8'd0,  1, 0, 0, 0, 8'd4,  1, 0, 0));
        vecs.push_back(mk("en0_hold1",  0, 8'd0,  0, 0, 0, 0, 8'd4,  1, 0, 0));
        vecs.push_back(mk("en0_hold2",  0, 8'd0,  0, 0, 0, 0, 8'd4,  1, 0, 0));
        vecs.push_back(mk("en1_dec",    0, 8'd0,  0, 0, 0, 1, 8'd3,  1, 0, 0));
        vecs.push_back(mk("pr_load10",  1, 8'd10, 0, 0, 0, 1, 8'd10, 0, 0, 0));
        vecs.push_back(mk("pr_start",   0, 8'd0,  1, 0, 0, 1, 8'd10, 1, 0, 0));
        vecs.push_back(mk("pr_9",       0, 8'd0,  0, 0, 0, 1, 8'd9,  1, 0, 0));
        vecs.push_back(mk("pr_8",       0, 8'd0,  0, 0, 0, 1, 8'd8,  1, 0, 0));
        vecs.push_back(mk("pr_7",       0, 8'd0,  0, 0, 0, 1, 8'd7,  1, 0, 0));
        vecs.push_back(mk("pr_stop",    0, 8'd0,  0, 1, 0, 1, 8'd7,  0, 1, 0));
        vecs.push_back(mk("pr_hold1",   0, 8'd0,  0, 0, 0, 1, 8'd7,  0, 1, 0));
        vecs.push_back(mk("pr_hold2",   0, 8'd0,  0, 0, 0, 1, 8'd7,  0, 1, 0));
        vecs.push_back(mk("pr_hold3",   0, 8'd0,  0, 0, 0, 1, 8'd7,  0, 1, 0));
        vecs.push_back(mk("pr_resume",  0, 8'd0,  1, 0, 0, 1, 8'd7,  1, 0, 0));
        vecs.push_back(mk("pr_6",       0, 8'd0,  0, 0, 0, 1, 8'd6,  1, 0, 0));
        vecs.push_back(mk("pr_5",       0, 8'd0,  0, 0, 0, 1, 8'd5,  1, 0, 0));
        vecs.push_back(mk("stop_start", 0, 8'd0,  1, 1, 0, 1, 8'd5,  0, 1, 0));
        vecs.push_back(mk("pr_resume2", 0, 8'd0,  1, 0, 0, 1, 8'd5,  1, 0, 0));
        vecs.push_back(mk("stop_tick",  0, 8'd0,  0, 1, 0, 1, 8'd5,  0, 1, 0));
        vecs.push_back(mk("stop_pause", 0, 8'd0,  0, 1, 0, 1, 8'd5,  0, 1, 0));
        vecs.push_back(mk("pr_resume3", 0, 8'd0,  1, 0, 0, 1, 8'd5,  1, 0, 0));
        vecs.push_back(mk("pr_4",       0, 8'd0,  0, 0, 0, 1, 8'd4,  1, 0, 0));
        vecs.push_back(mk("one_load",   1, 8'd1,  0, 0, 0, 1, 8'd1,  0, 0, 0));
        vecs.push_back(mk("one_start",  0, 8'd0,  1, 0, 0, 1, 8'd1,  1, 0, 0));
        vecs.push_back(mk("one_expire", 0, 8'd0,  0, 0, 0, 1, 8'd0,  0, 0, 1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].load, vecs[i].load_value, vecs[i].start, vecs[i].stop,
                          vecs[i].auto_reload, vecs[i].enable);
            checkOutput(vecs[i].name, vecs[i].exp_count, vecs[i].exp_busy,
                        vecs[i].exp_paused, vecs[i].exp_expire);
        end

        // Asynchronous reset in the middle of a run, one cycle before expiry.
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("pre_reset", 8'd1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_no_expire", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DOWN_TIMER_PRESCALE_EN
        // presc=2: one decrement per three enabled cycles, expire six cycles after start.
        tif.presc = 4'd2;
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("ps_start", 8'd2, 1'b1, 1'b0, 1'b0);
        begin
            logic [7:0] ps_cnt[6];
            logic       ps_exp[6];
            ps_cnt = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0};
            ps_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int k = 0; k < 6; k++) begin
                applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
                checkOutput($sformatf("ps_cycle%0d", k + 1), ps_cnt[k], (k != 5), 1'b0, ps_exp[k]);
            end
        end
        tif.presc = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
